sr_latch_nor_core: RTL and testbench

Clocked, multi-bit emulation of a cross-coupled NOR SR latch. Each bit reproduces NOR-latch truth-table behaviour: set, reset, hold, and the S=R=1 "both outputs low" condition. It also detects and resolves the race that follows that condition. The block sits in the digital-circuits library as a synthesizable, glitch-free replacement for combinational latches, with status flags for invalid-input monitoring.

---
 rtl/sr_latch_nor_core_if.sv | 28 ++
 rtl/sr_latch_nor_core.sv | 102 ++++++++++
 tb/tb_sr_latch_nor_core.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sr_latch_nor_core_if.sv
// Bundles the set/reset requests, flag clear and latch status outputs of sr_latch_nor_core.
// Latency: none (wires only).
// Backpressure: none; every field is sampled or driven on every clock edge.
interface sr_latch_nor_core_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] R;
  logic             clr_flags;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qn;
  logic [WIDTH-1:0] invalid;
  logic [WIDTH-1:0] race;
  logic [CNT_W-1:0] inv_count;

  // Stimulus side: drives requests, observes latch state.
  modport master (
    output S, R, clr_flags,
    input  Q, Qn, invalid, race, inv_count
  );

  // Latch side: samples requests, drives latch state.
  modport slave (
    input  S, R, clr_flags,
    output Q, Qn, invalid, race, inv_count
  );
endinterface

// File: rtl/sr_latch_nor_core.sv
// Clocked multi-bit NOR SR latch with invalid-state detection, race flags and a saturating invalid counter.
// Latency: one cycle from S/R to Q/Qn/invalid; all outputs come straight from registers.
// Backpressure: none; requests are accepted on every edge once the reset release has propagated.
module sr_latch_nor_core #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sr_latch_nor_core_if.slave   bus
);

  // Encoding is {Q, Qn}, so the outputs are plain register bits.
  typedef enum logic [1:0] {
    ST_INV   = 2'b00,
    ST_RESET = 2'b01,
    ST_SET   = 2'b10
  } state_e;

  // Wide enough to hold the current count plus every bit entering at once.
  localparam int SUM_W = CNT_W + $clog2(WIDTH + 1) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  state_e           st_q [WIDTH];
  state_e           st_d [WIDTH];
  logic [WIDTH-1:0] race_q, race_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] enter;
  logic [WIDTH-1:0] race_evt;
  logic [SUM_W-1:0] sum;
  logic             rel_q;

  // Retime reset release: rel_q rises on the first edge after rst_n, state moves on the second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rel_q <= 1'b0;
    else        rel_q <= 1'b1;
  end

  // Per-bit NOR-latch next state; S=R=0 out of INVALID resolves to RESET and flags a race.
  always_comb begin
    enter    = '0;
    race_evt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      st_d[i] = st_q[i];
      unique case ({bus.S[i], bus.R[i]})
        2'b10:   st_d[i] = ST_SET;
        2'b01:   st_d[i] = ST_RESET;
        2'b11:   st_d[i] = ST_INV;
        default: begin
          if (st_q[i] == ST_INV) begin
            st_d[i]     = ST_RESET;
            race_evt[i] = 1'b1;
          end
        end
      endcase
      enter[i] = (st_q[i] != ST_INV) && (st_d[i] == ST_INV);
    end
  end

  // Flag and counter update; clr_flags overrides any event in the same cycle.
  always_comb begin
    sum = {{(SUM_W-CNT_W){1'b0}}, cnt_q};
    for (int i = 0; i < WIDTH; i++) begin
      sum = sum + {{(SUM_W-1){1'b0}}, enter[i]};
    end
    cnt_d  = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    race_d = race_q | race_evt;
    if (bus.clr_flags) begin
      cnt_d  = '0;
      race_d = '0;
    end
  end

  // State registers; reset discards everything, including an INVALID bit, without raising race.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) st_q[i] <= ST_RESET;
      race_q <= '0;
      cnt_q  <= '0;
    end else if (rel_q) begin
      st_q   <= st_d;
      race_q <= race_d;
      cnt_q  <= cnt_d;
    end
  end

  // Decode registered state onto the outputs.
  always_comb begin
    bus.Q       = '0;
    bus.Qn      = '0;
    bus.invalid = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bus.Q[i]       = st_q[i][1];
      bus.Qn[i]      = st_q[i][0];
      bus.invalid[i] = (st_q[i] == ST_INV);
    end
  end

  assign bus.race      = race_q;
  assign bus.inv_count = cnt_q;

endmodule

// File: tb/tb_sr_latch_nor_core.sv
// Directed bench for sr_latch_nor_core: single-bit truth table, narrow counter saturation, four-bit mix, reset.
// Latency: checks sample 1 time unit after the rising edge.
// Backpressure: not applicable.
module tb_sr_latch_nor_core;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  sr_latch_nor_core_if #(.WIDTH(1), .CNT_W(8)) if1 ();
  sr_latch_nor_core_if #(.WIDTH(1), .CNT_W(2)) if2 ();
  sr_latch_nor_core_if #(.WIDTH(4), .CNT_W(8)) if4 ();

  sr_latch_nor_core #(.WIDTH(1), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  sr_latch_nor_core #(.WIDTH(1), .CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  sr_latch_nor_core #(.WIDTH(4), .CNT_W(8)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  always #5 clk = ~clk;

  // One vector: inputs plus expected {Q, Qn, invalid, race, inv_count[7:0]}.
  typedef struct {
    logic        s;
    logic        r;
    logic        clr;
    logic [11:0] exp;
  } vec_t;

  vec_t vt [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] st1();
    return {if1.Q, if1.Qn, if1.invalid, if1.race, if1.inv_count};
  endfunction

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    n_pass = 0;
    n_total = 0;
    if1.S = '0; if1.R = '0; if1.clr_flags = 1'b0;
    if2.S = '0; if2.R = '0; if2.clr_flags = 1'b0;
    if4.S = '0; if4.R = '0; if4.clr_flags = 1'b0;

    //            s     r     clr     Q Qn inv race  cnt
    vt[0]  = '{1'b0, 1'b0, 1'b0, {4'b0100, 8'd0}};
    vt[1]  = '{1'b1, 1'b0, 1'b0, {4'b1000, 8'd0}};
    vt[2]  = '{1'b0, 1'b0, 1'b0, {4'b1000, 8'd0}};
    vt[3]  = '{1'b0, 1'b1, 1'b0, {4'b0100, 8'd0}};
    vt[4]  = '{1'b0, 1'b0, 1'b0, {4'b0100, 8'd0}};
    vt[5]  = '{1'b1, 1'b1, 1'b0, {4'b0010, 8'd1}};
    vt[6]  = '{1'b0, 1'b0, 1'b0, {4'b0101, 8'd1}};
    vt[7]  = '{1'b0, 1'b0, 1'b1, {4'b0100, 8'd0}};
    vt[8]  = '{1'b1, 1'b1, 1'b0, {4'b0010, 8'd1}};
    vt[9]  = '{1'b1, 1'b0, 1'b0, {4'b1000, 8'd1}};
    vt[10] = '{1'b1, 1'b1, 1'b0, {4'b0010, 8'd2}};
    vt[11] = '{1'b0, 1'b1, 1'b0, {4'b0100, 8'd2}};
    vt[12] = '{1'b1, 1'b1, 1'b0, {4'b0010, 8'd3}};
    // clr_flags on the very edge the race happens: state resolves, flags stay clear
    vt[13] = '{1'b0, 1'b0, 1'b1, {4'b0100, 8'd0}};

    // Reset state while rst_n is held low
    #12;
    check("reset_w1", st1(), {4'b0100, 8'd0});
    check("reset_w4", {if4.Q, if4.Qn, if4.invalid, if4.race, if4.inv_count},
          {4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'd0});
    rst_n = 1'b1;
    tick(3);

    // Single-bit truth table: check one cycle after the change and again after five
    for (int k = 0; k < 14; k++) begin
      if1.S = vt[k].s;
      if1.R = vt[k].r;
      if1.clr_flags = vt[k].clr;
      tick(1);
      check($sformatf("vec%0d_lat1", k), st1(), vt[k].exp);
      tick(4);
      check($sformatf("vec%0d_hold5", k), st1(), vt[k].exp);
    end
    if1.S = '0; if1.R = '0; if1.clr_flags = 1'b0;
    tick(1);
    check("after_clr_race", st1(), {4'b0100, 8'd0});

    // Two-bit counter: five separate invalid entries saturate at 3
    for (int k = 0; k < 5; k++) begin
      if2.S = 1'b1; if2.R = 1'b1;
      tick(1);
      if2.S = 1'b0; if2.R = 1'b1;
      tick(1);
      check($sformatf("sat_pulse%0d", k), if2.inv_count, (k < 3) ? k + 1 : 3);
    end
    if2.clr_flags = 1'b1;
    tick(1);
    if2.clr_flags = 1'b0;
    check("sat_clr", if2.inv_count, 0);
    // Staying in INVALID counts only the entry
    if2.S = 1'b1; if2.R = 1'b1;
    tick(10);
    check("hold_inv_cnt", {if2.invalid, if2.inv_count}, {1'b1, 2'd1});
    if2.S = 1'b0; if2.R = 1'b1;
    tick(1);
    check("hold_inv_exit", {if2.Q, if2.Qn, if2.invalid, if2.race}, 4'b0100);

    // Four bits: set, reset, invalid and hold in one edge
    if4.S = 4'b1010; if4.R = 4'b0110;
    tick(1);
    check("w4_mix_Q", if4.Q, 4'b1000);
    check("w4_mix_Qn", if4.Qn, 4'b0101);
    check("w4_mix_inv", {if4.invalid, if4.inv_count}, {4'b0010, 8'd1});
    // Three new entries in one edge; bit 1 was already invalid
    if4.S = 4'b1111; if4.R = 4'b1111;
    tick(1);
    check("w4_multi_enter", {if4.invalid, if4.inv_count}, {4'b1111, 8'd4});
    if4.S = 4'b0000; if4.R = 4'b0000;
    tick(1);
    check("w4_race_all", {if4.Q, if4.Qn, if4.invalid, if4.race, if4.inv_count},
          {4'b0000, 4'b1111, 4'b0000, 4'b1111, 8'd4});
    // Park w4 in INVALID and w1 in SET before the asynchronous reset
    if4.S = 4'b1111; if4.R = 4'b1111;
    if1.S = 1'b1;
    tick(1);
    if1.S = 1'b0;
    if4.S = 4'b0000; if4.R = 4'b0000;
    check("pre_reset_w1", if1.Q, 1'b1);

    // Asynchronous reset mid-cycle, observed before the next edge
    #2 rst_n = 1'b0;
    #1;
    check("areset_w1", st1(), {4'b0100, 8'd0});
    check("areset_w4", {if4.Q, if4.Qn, if4.invalid, if4.race, if4.inv_count},
          {4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'd0});
    check("areset_w2", {if2.Q, if2.Qn, if2.invalid, if2.race, if2.inv_count}, 6'b010000);

    // Release: first edge only arms, second edge updates
    if1.S = 1'b1;
    #2 rst_n = 1'b1;
    tick(1);
    check("release_edge1", if1.Q, 1'b0);
    tick(1);
    check("release_edge2", {if1.Q, if1.Qn}, 2'b10);
    if1.S = 1'b0;
    tick(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
